bht_predictor: RTL and testbench
================================

Name: bht_predictor

Overview:
- Branch history table. Stores one 2-bit saturating counter per entry.
- Fetch side reads a counter to produce a taken/not-taken prediction.
- Execute side writes resolved outcomes back as saturating increment/decrement.
- Sits between the fetch PC generator (prediction port) and the branch resolution stage (update port).

Parameters:
- INDEX_BITS, 6, log2 of table entries (default 64 entries).
- PC_WIDTH, 32, width of PC inputs.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- pred_valid  in  1  prediction request this cycle.
- pred_pc  in  PC_WIDTH  PC of the fetched branch.
- pred_out_valid  out  1  registered; high one cycle after an accepted pred_valid.
- pred_taken  out  1  registered prediction (counter MSB).
- upd_valid  in  1  resolved branch outcome is present.
- upd_pc  in  PC_WIDTH  PC of the resolved branch.
- upd_taken  in  1  actual outcome (1 = taken).
- init_busy  out  1  high while the table clear sweep runs.

Behaviour:
- Index: idx = pc[INDEX_BITS+1:2]. Upper PC bits are ignored, so aliasing is permitted.
- Counter encoding:
  - 00 strongly not-taken
  - 01 weakly not-taken
  - 10 weakly taken
  - 11 strongly taken
- Prediction is the counter MSB.
- State machine, states INIT and RUN:
  - rst (any cycle, including mid-run) forces INIT with sweep pointer = 0.
  - INIT: each cycle writes 01 to entry[pointer] and increments the pointer. After entry 2^INDEX_BITS-1 is written, the next state is RUN.
  - The sweep takes exactly 2^INDEX_BITS cycles after the rst-low edge.
  - init_busy = 1 in INIT (including the reset cycle), 0 in RUN.
- Prediction: 1-cycle latency.
  - pred_valid at cycle t gives pred_out_valid = 1 and pred_taken valid at t+1.
  - pred_valid low gives pred_out_valid = 0 at t+1, and pred_taken holds its last value.
  - In INIT, requests are still answered: pred_out_valid = 1, pred_taken = 0.
- Update: single-cycle read-modify-write, in RUN only.
  - upd_taken = 1: counter + 1, saturating at 11.
  - upd_taken = 0: counter - 1, saturating at 00.
  - Updates in INIT are dropped.
- Simultaneous predict and update to the same idx in the same cycle: the prediction reflects the post-update counter (write-to-read bypass).
- Different idx in the same cycle: both complete independently.
- Reset values: pred_out_valid = 0, pred_taken = 0, init_busy = 1, state = INIT.
- Table contents are defined only after the sweep. Storage may infer as LUTRAM: one combinational read port for prediction, one read plus one write port for update/sweep.
- No back-pressure; both ports accept every cycle.

Optional Feature:
- Macro: BHT_GSHARE_EN.
- When defined:
  - Adds an INDEX_BITS-wide global history register ghr, reset to 0 and held at 0 in INIT.
  - In RUN, each upd_valid shifts it: ghr <= {ghr[INDEX_BITS-2:0], upd_taken}.
  - Both ports use idx = pc[INDEX_BITS+1:2] ^ ghr, using the value of ghr before that cycle's shift.
  - The bypass rule compares the XORed indices.
- When undefined: no ghr, pure PC indexing as above.

Test Plan:
- Reset sweep: rst high 1 cycle, then low → init_busy = 1 for 64 cycles, then 0. Predict pc 0x0000_0100 → pred_taken = 0 next cycle. An update issued during the sweep leaves the counter at 01.
- Training: two updates, upd_pc = 0x100, upd_taken = 1 → predict 0x100 gives pred_taken = 1. Predict 0x104 (idx 1) gives 0.
- Saturation: 5 taken updates to 0x100 (counter 11), then 1 not-taken → still predicts 1. 2nd not-taken → predicts 0. 3rd and 4th not-taken → counter 00; one taken then still predicts 0.
- Bypass: counter at 01; same cycle pred_pc = upd_pc = 0x100, upd_taken = 1 → pred_taken = 1 at t+1.
- Aliasing: train 0x100 to 11 → predict 0x200 (same idx 0) returns 1 (base build).
- Reset mid-run: train several entries, assert rst → sweep restarts from 0 and all predictions return 0 afterwards. Under BHT_GSHARE_EN, ghr also reads 0 and 0x100 indexes entry 0.

Source files
------------

// File: rtl/bht_predictor.sv
// bht_predictor: branch history table of 2-bit saturating counters.
// The fetch port reads a counter and returns its MSB as the prediction one
// cycle later; the execute port applies resolved outcomes as saturating
// increment/decrement.
// After reset the table is swept to weakly-not-taken (01), one entry per cycle.
// Optional feature: define BHT_GSHARE_EN to XOR a global history register
// into both table indices (gshare indexing).
module bht_predictor #(
    parameter int INDEX_BITS = 6,
    parameter int PC_WIDTH   = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pred_valid,
    input  logic [PC_WIDTH-1:0] pred_pc,
    output logic                pred_out_valid,
    output logic                pred_taken,
    input  logic                upd_valid,
    input  logic [PC_WIDTH-1:0] upd_pc,
    input  logic                upd_taken,
    output logic                init_busy
);

    localparam int DEPTH = 1 << INDEX_BITS;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [INDEX_BITS-1:0]   sweep_ptr_q;

    // Counter storage; no reset so it can map onto distributed RAM.
    logic [1:0]              bht_mem [DEPTH];

    logic [INDEX_BITS-1:0]   pred_idx;
    logic [INDEX_BITS-1:0]   upd_idx;
    logic [1:0]              pred_cnt;
    logic [1:0]              upd_cnt;
    logic [1:0]              upd_next;
    logic                    upd_fire;
    logic                    bypass_hit;
    logic                    pred_bit;

    logic                    mem_we;
    logic [INDEX_BITS-1:0]   mem_waddr;
    logic [1:0]              mem_wdata;

    // Upper and byte-offset PC bits do not take part in indexing.
    logic                    unused_pc_bits;
    assign unused_pc_bits = ^{pred_pc[PC_WIDTH-1:INDEX_BITS+2], pred_pc[1:0],
                              upd_pc[PC_WIDTH-1:INDEX_BITS+2], upd_pc[1:0]};

`ifdef BHT_GSHARE_EN
    logic [INDEX_BITS-1:0]   ghr_q;

    // Global history: cleared during the sweep, shifts in each resolved outcome.
    always_ff @(posedge clk) begin
        if (rst) begin
            ghr_q <= '0;
        end else if (state_q == ST_INIT) begin
            ghr_q <= '0;
        end else if (upd_valid) begin
            ghr_q <= {ghr_q[INDEX_BITS-2:0], upd_taken};
        end
    end

    // Both ports hash with the history value from before this cycle's shift.
    always_comb begin
        pred_idx = pred_pc[INDEX_BITS+1:2] ^ ghr_q;
        upd_idx  = upd_pc[INDEX_BITS+1:2] ^ ghr_q;
    end
`else
    // Pure PC indexing; aliasing between PCs sharing the low bits is allowed.
    always_comb begin
        pred_idx = pred_pc[INDEX_BITS+1:2];
        upd_idx  = upd_pc[INDEX_BITS+1:2];
    end
`endif

    // State register and sweep pointer; reset restarts the sweep from entry 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_INIT;
            sweep_ptr_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_INIT) begin
                sweep_ptr_q <= sweep_ptr_q + INDEX_BITS'(1);
            end
        end
    end

    // Next state: leave INIT once the last entry has been written.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT: begin
                if (sweep_ptr_q == '1) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    assign init_busy = (state_q == ST_INIT);

    // Update read side and saturating counter arithmetic.
    always_comb begin
        upd_cnt  = bht_mem[upd_idx];
        upd_fire = upd_valid && (state_q == ST_RUN) && !rst;
        upd_next = upd_cnt;
        if (upd_taken) begin
            if (upd_cnt != 2'b11) begin
                upd_next = upd_cnt + 2'd1;
            end
        end else begin
            if (upd_cnt != 2'b00) begin
                upd_next = upd_cnt - 2'd1;
            end
        end
    end

    // Single write port shared by the clear sweep and resolved updates.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        if (state_q == ST_INIT) begin
            mem_we    = 1'b1;
            mem_waddr = sweep_ptr_q;
            mem_wdata = 2'b01;
        end else if (upd_fire) begin
            mem_we    = 1'b1;
            mem_waddr = upd_idx;
            mem_wdata = upd_next;
        end
    end

    // Table write.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            bht_mem[mem_waddr] <= mem_wdata;
        end
    end

    // Prediction read with write-to-read bypass for a same-index update.
    always_comb begin
        pred_cnt   = bht_mem[pred_idx];
        bypass_hit = upd_fire && (upd_idx == pred_idx);
        if (state_q == ST_INIT) begin
            pred_bit = 1'b0;
        end else if (bypass_hit) begin
            pred_bit = upd_next[1];
        end else begin
            pred_bit = pred_cnt[1];
        end
    end

    // Registered prediction outputs; pred_taken holds when no request arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            pred_out_valid <= 1'b0;
            pred_taken     <= 1'b0;
        end else begin
            pred_out_valid <= pred_valid;
            if (pred_valid) begin
                pred_taken <= pred_bit;
            end
        end
    end

endmodule

// File: tb/tb_bht_predictor.sv
// Scoreboard bench for bht_predictor (default build, PC indexing).
// The driver pushes the expected prediction when it issues a request; a
// monitor pops and compares on every cycle the DUT presents pred_out_valid.
module tb_bht_predictor;

    logic        clk;
    logic        rst;
    logic        pred_valid;
    logic [31:0] pred_pc;
    logic        pred_out_valid;
    logic        pred_taken;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic        init_busy;

    int          n_checks;
    int          n_pass;
    logic        exp_q[$];
    string       name_q[$];
    int          busy_cnt;

    bht_predictor #(
        .INDEX_BITS(6),
        .PC_WIDTH  (32)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pred_valid    (pred_valid),
        .pred_pc       (pred_pc),
        .pred_out_valid(pred_out_valid),
        .pred_taken    (pred_taken),
        .upd_valid     (upd_valid),
        .upd_pc        (upd_pc),
        .upd_taken     (upd_taken),
        .init_busy     (init_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: timeout reached, checks %0d passed %0d", n_checks, n_pass);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic got, input logic exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", name, got, exp);
    endtask

    // Monitor: every presented prediction is matched against the scoreboard.
    always @(negedge clk) begin
        if (pred_out_valid === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_pred: got pred_out_valid=1 with pred_taken=%b, expected no output", pred_taken);
            end else begin
                automatic logic  e = exp_q.pop_front();
                automatic string n = name_q.pop_front();
                if (pred_taken === e) n_pass++;
                else $display("FAIL %s: got pred_taken=%b expected %b", n, pred_taken, e);
            end
        end
    end

    // One cycle of stimulus; a prediction request queues its expected answer.
    task automatic drive(input logic pv, input logic [31:0] ppc, input logic exp,
                         input string name, input logic uv, input logic [31:0] upc,
                         input logic ut);
        pred_valid = pv;
        pred_pc    = ppc;
        upd_valid  = uv;
        upd_pc     = upc;
        upd_taken  = ut;
        if (pv) begin
            exp_q.push_back(exp);
            name_q.push_back(name);
        end
        @(posedge clk);
        #1;
        pred_valid = 1'b0;
        upd_valid  = 1'b0;
    endtask

    task automatic predict(input logic [31:0] pc, input logic exp, input string name);
        drive(1'b1, pc, exp, name, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic update(input logic [31:0] pc, input logic t);
        drive(1'b0, 32'h0, 1'b0, "", 1'b1, pc, t);
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 1'b0, "", 1'b0, 32'h0, 1'b0);
    endtask

    // Count busy cycles of a sweep while injecting stimulus into INIT.
    task automatic run_sweep(input bit first, output int cnt);
        cnt = 0;
        for (int i = 0; i < 200; i++) begin
            if (init_busy !== 1'b1) break;
            cnt++;
            if (first && i == 5)       update(32'h100, 1'b1);
            else if (first && i == 6)  predict(32'h100, 1'b0, "init_pred");
            else if (!first && i == 0) predict(32'h108, 1'b0, "init_pred_after_rst");
            else                       idle();
        end
    endtask

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        rst        = 1'b1;
        pred_valid = 1'b0;
        pred_pc    = '0;
        upd_valid  = 1'b0;
        upd_pc     = '0;
        upd_taken  = 1'b0;

        // Reset state
        @(posedge clk);
        #1;
        check("rst_pred_out_valid", pred_out_valid, 1'b0);
        check("rst_pred_taken", pred_taken, 1'b0);
        check("rst_init_busy", init_busy, 1'b1);
        rst = 1'b0;

        run_sweep(1'b1, busy_cnt);
        n_checks++;
        if (busy_cnt == 64) n_pass++;
        else $display("FAIL sweep_len: got %0d busy cycles expected 64", busy_cnt);

        // Counters start at 01; the update issued during INIT was dropped.
        predict(32'h100, 1'b0, "post_sweep_0x100");
        predict(32'h104, 1'b0, "post_sweep_0x104");

        // Bypass: 01 -> 10 in the same cycle as the prediction.
        drive(1'b1, 32'h100, 1'b1, "bypass_taken", 1'b1, 32'h100, 1'b1);
        update(32'h100, 1'b1);                          // 11
        predict(32'h100, 1'b1, "trained_0x100");
        predict(32'h104, 1'b0, "untrained_0x104");
        predict(32'h200, 1'b1, "alias_0x200");

        // No request: valid drops, taken holds its previous value.
        idle();
        check("idle_pred_out_valid", pred_out_valid, 1'b0);
        check("hold_pred_taken", pred_taken, 1'b1);

        // Saturation on idx 3, starting from 01.
        for (int k = 0; k < 5; k++) update(32'h10C, 1'b1);   // 11
        update(32'h10C, 1'b0);                               // 10
        predict(32'h10C, 1'b1, "sat_hi_nt1");
        update(32'h10C, 1'b0);                               // 01
        predict(32'h10C, 1'b0, "sat_hi_nt2");
        update(32'h10C, 1'b0);                               // 00
        update(32'h10C, 1'b0);                               // 00
        update(32'h10C, 1'b1);                               // 01
        predict(32'h10C, 1'b0, "sat_lo_t1");
        update(32'h10C, 1'b1);                               // 10
        predict(32'h10C, 1'b1, "sat_lo_t2");

        // Different indices in the same cycle complete independently.
        drive(1'b1, 32'h104, 1'b0, "diff_idx_pred", 1'b1, 32'h108, 1'b1);  // idx2 -> 10
        predict(32'h108, 1'b1, "diff_idx_upd");
        drive(1'b1, 32'h108, 1'b0, "bypass_not_taken", 1'b1, 32'h108, 1'b0); // idx2 -> 01

        // Mid-run reset with trained entries.
        update(32'h108, 1'b1);                               // idx2 -> 10
        predict(32'h100, 1'b1, "pre_reset_0x100");
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0, "", 1'b1, 32'h104, 1'b1);
        rst = 1'b0;
        check("midrst_pred_out_valid", pred_out_valid, 1'b0);
        check("midrst_pred_taken", pred_taken, 1'b0);
        check("midrst_init_busy", init_busy, 1'b1);

        run_sweep(1'b0, busy_cnt);
        n_checks++;
        if (busy_cnt == 64) n_pass++;
        else $display("FAIL sweep_len_after_rst: got %0d busy cycles expected 64", busy_cnt);

        predict(32'h100, 1'b0, "after_rst_0x100");
        predict(32'h104, 1'b0, "after_rst_0x104");
        predict(32'h108, 1'b0, "after_rst_0x108");
        predict(32'h10C, 1'b0, "after_rst_0x10C");
        predict(32'h200, 1'b0, "after_rst_0x200");

        idle();
        idle();
        idle();
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL queue_drain: got %0d outstanding predictions expected 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
